// File: rtl/prog_lut_eval.sv
// Programmable N-input truth-table evaluator with a serial reload port and a saturating hit counter.
// Result is registered one cycle after in_valid; there is no backpressure and a load never stalls evaluation.
module prog_lut_eval #(
   parameter int                 N_IN  = 3,
   parameter logic [2**N_IN-1:0] INIT  = 8'b0011_0001,
   parameter int                 CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [N_IN-1:0]      in_data,
   output logic                 out_valid,
   output logic                 y,
   input  logic                 cfg_start,
   input  logic                 cfg_valid,
   input  logic                 cfg_bit,
   input  logic                 cfg_abort,
   output logic                 cfg_busy,
   output logic                 cfg_done,
   output logic [2**N_IN-1:0]   table_out,
   input  logic                 cnt_clr,
   output logic [CNT_W-1:0]     hit_count
);
   localparam int TBL = 2**N_IN;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] LOAD = 1'b1;

   logic [0:0]      state;
   logic [TBL-1:0]  active_table;
   logic [TBL-1:0]  shadow;
   logic [N_IN-1:0] bit_cnt;
   logic            lut_hit;
   logic            last_bit;

   assign lut_hit   = active_table[in_data];
   // The final bit is accepted when the counter already holds TBL-1.
   assign last_bit  = (state == LOAD) && !cfg_abort && !cfg_start && cfg_valid && (&bit_cnt);
   assign table_out = active_table;
   assign cfg_busy  = (state == LOAD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         y         <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid)
            y <= lut_hit;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         active_table <= INIT;
         shadow       <= '0;
         bit_cnt      <= '0;
         cfg_done     <= 1'b0;
      end else begin
         cfg_done <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_start) begin
                  state   <= LOAD;
                  bit_cnt <= '0;
               end
            end
            LOAD: begin
               if (cfg_abort) begin
                  state   <= IDLE;
                  shadow  <= '0;
                  bit_cnt <= '0;
               end else if (cfg_start) begin
                  bit_cnt <= '0;
               end else if (cfg_valid) begin
                  shadow  <= {shadow[TBL-2:0], cfg_bit};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (last_bit) begin
                     active_table <= {shadow[TBL-2:0], cfg_bit};
                     state        <= IDLE;
                     cfg_done     <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Clear beats increment; the counter sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         hit_count <= '0;
      else if (cnt_clr)
         hit_count <= '0;
      else if (in_valid && lut_hit && !(&hit_count))
         hit_count <= hit_count + CNT_W'(1);
   end
endmodule

// File: tb/tb_prog_lut_eval.sv
// Directed bench for prog_lut_eval: evaluation, serial loads, abort/restart, counter saturation, async reset.
module tb_prog_lut_eval;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [2:0] in_data = '0;
   logic       out_valid, y;
   logic       cfg_start = 1'b0, cfg_valid = 1'b0, cfg_bit = 1'b0, cfg_abort = 1'b0;
   logic       cfg_busy, cfg_done;
   logic [7:0] table_out;
   logic       cnt_clr = 1'b0;
   logic [7:0] hit_count;

   // Second instance with a 2-bit counter for saturation checks
   logic       s_in_valid = 1'b0;
   logic [2:0] s_in_data = '0;
   logic       s_cnt_clr = 1'b0;
   logic       s_out_valid, s_y, s_cfg_busy, s_cfg_done;
   logic [7:0] s_table_out;
   logic [1:0] s_hit_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   prog_lut_eval #(.N_IN(3), .INIT(8'b0011_0001), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .y(y), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
      .cfg_bit(cfg_bit), .cfg_abort(cfg_abort), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
      .table_out(table_out), .cnt_clr(cnt_clr), .hit_count(hit_count)
   );

   prog_lut_eval #(.N_IN(3), .INIT(8'b0011_0001), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_data(s_in_data),
      .out_valid(s_out_valid), .y(s_y), .cfg_start(1'b0), .cfg_valid(1'b0),
      .cfg_bit(1'b0), .cfg_abort(1'b0), .cfg_busy(s_cfg_busy), .cfg_done(s_cfg_done),
      .table_out(s_table_out), .cnt_clr(s_cnt_clr), .hit_count(s_hit_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_abort = 1'b0; cnt_clr = 1'b0;
      s_in_valid = 1'b0; s_cnt_clr = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (table_out !== 8'h31) begin n_fail++; $display("FAIL reset_table got=%h exp=31", table_out); end
      n_checks++; if (y !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out got y=%b ov=%b exp 0/0", y, out_valid); end
      n_checks++; if (cfg_busy !== 1'b0 || cfg_done !== 1'b0) begin n_fail++; $display("FAIL reset_cfg got busy=%b done=%b exp 0/0", cfg_busy, cfg_done); end
      n_checks++; if (hit_count !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", hit_count); end
   endtask

   task automatic test_eval();
      logic [7:0] exp_y;
      exp_y = 8'b0011_0001;  // y for in_data = 0..7 under the default table
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = 3'(i);
         step();
         n_checks++; if (y !== exp_y[i] || out_valid !== 1'b1) begin n_fail++; $display("FAIL eval_%0d got y=%b ov=%b exp y=%b ov=1", i, y, out_valid, exp_y[i]); end
      end
      in_valid = 1'b0;
      step();
      n_checks++; if (out_valid !== 1'b0 || y !== 1'b0) begin n_fail++; $display("FAIL eval_idle got ov=%b y=%b exp 0/0", out_valid, y); end
      n_checks++; if (hit_count !== 8'd3) begin n_fail++; $display("FAIL eval_hits got=%0d exp=3", hit_count); end
   endtask

   task automatic test_load();
      int done_pulses;
      logic [7:0] pat;
      done_pulses = 0;
      pat = 8'h80;
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      n_checks++; if (cfg_busy !== 1'b1) begin n_fail++; $display("FAIL load_busy_start got=%b exp=1", cfg_busy); end
      for (int k = 7; k >= 0; k--) begin
         cfg_valid = 1'b1; cfg_bit = pat[k];
         step();
         cfg_valid = 1'b0;
         if (cfg_done) done_pulses++;
         if (k > 0) begin
            if (cfg_busy !== 1'b1) begin n_checks++; n_fail++; $display("FAIL load_busy_bit%0d got=0 exp=1", k); end
            step();
            if (cfg_done) done_pulses++;
         end
      end
      n_checks++; if (cfg_busy !== 1'b0 || cfg_done !== 1'b1) begin n_fail++; $display("FAIL load_commit got busy=%b done=%b exp 0/1", cfg_busy, cfg_done); end
      n_checks++; if (table_out !== 8'h80) begin n_fail++; $display("FAIL load_table got=%h exp=80", table_out); end
      in_valid = 1'b1; in_data = 3'd7;
      step();
      if (cfg_done) done_pulses++;
      n_checks++; if (y !== 1'b1) begin n_fail++; $display("FAIL load_eval7 got=%b exp=1", y); end
      in_data = 3'd0;
      step();
      in_valid = 1'b0;
      n_checks++; if (y !== 1'b0) begin n_fail++; $display("FAIL load_eval0 got=%b exp=0", y); end
      n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL load_done_count got=%0d exp=1", done_pulses); end
   endtask

   task automatic test_commit_edge();
      do_reset();
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      cfg_valid = 1'b1; cfg_bit = 1'b1;
      step();
      cfg_bit = 1'b0;
      for (int k = 0; k < 6; k++) step();
      in_valid = 1'b1; in_data = 3'd0;  // evaluation coincides with the 8th bit
      step();
      cfg_valid = 1'b0;
      n_checks++; if (y !== 1'b1) begin n_fail++; $display("FAIL commit_old_table got=%b exp=1", y); end
      n_checks++; if (table_out !== 8'h80 || cfg_done !== 1'b1) begin n_fail++; $display("FAIL commit_state got tbl=%h done=%b exp 80/1", table_out, cfg_done); end
      step();
      in_valid = 1'b0;
      n_checks++; if (y !== 1'b0) begin n_fail++; $display("FAIL commit_new_table got=%b exp=0", y); end
   endtask

   task automatic test_abort_restart();
      logic [7:0] pat;
      do_reset();
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      cfg_valid = 1'b1; cfg_bit = 1'b1;
      for (int k = 0; k < 4; k++) step();
      cfg_abort = 1'b1;
      step();
      cfg_abort = 1'b0; cfg_valid = 1'b0;
      n_checks++; if (cfg_busy !== 1'b0 || cfg_done !== 1'b0) begin n_fail++; $display("FAIL abort_state got busy=%b done=%b exp 0/0", cfg_busy, cfg_done); end
      n_checks++; if (table_out !== 8'h31) begin n_fail++; $display("FAIL abort_table got=%h exp=31", table_out); end
      step();
      n_checks++; if (cfg_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got=%b exp=0", cfg_done); end
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      cfg_valid = 1'b1; cfg_bit = 1'b1;
      for (int k = 0; k < 3; k++) step();
      cfg_start = 1'b1;  // restart; the bit presented here must be dropped
      step();
      cfg_start = 1'b0;
      pat = 8'h5A;
      for (int k = 7; k >= 0; k--) begin
         cfg_bit = pat[k];
         step();
         if (k > 0 && cfg_busy !== 1'b1) begin n_checks++; n_fail++; $display("FAIL restart_early_commit bit%0d tbl=%h", k, table_out); end
      end
      cfg_valid = 1'b0;
      n_checks++; if (table_out !== 8'h5A || cfg_done !== 1'b1) begin n_fail++; $display("FAIL restart_table got tbl=%h done=%b exp 5a/1", table_out, cfg_done); end
   endtask

   task automatic test_saturate();
      logic [1:0] exp_cnt [4];
      exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3};
      do_reset();
      s_in_valid = 1'b1; s_in_data = 3'd0;
      for (int k = 0; k < 4; k++) begin
         step();
         n_checks++; if (s_hit_count !== exp_cnt[k]) begin n_fail++; $display("FAIL sat_cnt_%0d got=%0d exp=%0d", k, s_hit_count, exp_cnt[k]); end
      end
      s_cnt_clr = 1'b1;
      step();
      s_cnt_clr = 1'b0;
      n_checks++; if (s_hit_count !== 2'd0) begin n_fail++; $display("FAIL sat_clr got=%0d exp=0", s_hit_count); end
      s_in_data = 3'd1;  // table bit 1 is 0: no increment
      step();
      n_checks++; if (s_hit_count !== 2'd0) begin n_fail++; $display("FAIL sat_miss got=%0d exp=0", s_hit_count); end
      s_in_data = 3'd5;
      step();
      s_in_valid = 1'b0;
      n_checks++; if (s_hit_count !== 2'd1) begin n_fail++; $display("FAIL sat_after_clr got=%0d exp=1", s_hit_count); end
   endtask

   task automatic test_async_reset();
      logic [7:0] pat;
      do_reset();
      pat = 8'h80;
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      cfg_valid = 1'b1;
      for (int k = 7; k >= 0; k--) begin cfg_bit = pat[k]; step(); end
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      in_valid = 1'b1; in_data = 3'd7;
      for (int k = 0; k < 3; k++) step();
      n_checks++; if (cfg_busy !== 1'b1 || table_out !== 8'h80 || y !== 1'b1 || hit_count === 8'd0) begin n_fail++; $display("FAIL async_pre got busy=%b tbl=%h y=%b cnt=%0d exp 1/80/1/nonzero", cfg_busy, table_out, y, hit_count); end
      #3 reset = 1'b1;
      #1;
      n_checks++; if (cfg_busy !== 1'b0 || table_out !== 8'h31) begin n_fail++; $display("FAIL async_cfg got busy=%b tbl=%h exp 0/31", cfg_busy, table_out); end
      n_checks++; if (y !== 1'b0 || out_valid !== 1'b0 || hit_count !== 8'd0) begin n_fail++; $display("FAIL async_out got y=%b ov=%b cnt=%0d exp 0/0/0", y, out_valid, hit_count); end
      in_valid = 1'b0; cfg_valid = 1'b0;
      step();
      reset = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_eval();
      test_load();
      test_commit_edge();
      test_abort_restart();
      test_saturate();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
